alu_pipe: RTL and testbench

Pipelined, handshaked successor to the team's combinational ALU, for the TP datapath between the operand/opcode loader and the result/display stage.
- Operand width parametrised; shift amount derived from width.
- Adds SLL/SLT/SLTU, status flags and an illegal-opcode indication.
- Two register stages with valid/ready flow control: full throughput, lossless backpressure.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_core.sv | 90 +++++++++
 rtl/alu_pipe.sv | 95 +++++++++
 tb/tb_alu_pipe.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the pipelined ALU: MIPS funct opcodes and the
// bit positions of the status-flag vector carried alongside each result.
package alu_pkg;

   localparam int NB_OP = 6;

   localparam logic [NB_OP-1:0] OP_ADD  = 6'b100000;
   localparam logic [NB_OP-1:0] OP_SUB  = 6'b100010;
   localparam logic [NB_OP-1:0] OP_AND  = 6'b100100;
   localparam logic [NB_OP-1:0] OP_OR   = 6'b100101;
   localparam logic [NB_OP-1:0] OP_XOR  = 6'b100110;
   localparam logic [NB_OP-1:0] OP_NOR  = 6'b100111;
   localparam logic [NB_OP-1:0] OP_SLT  = 6'b101010;
   localparam logic [NB_OP-1:0] OP_SLTU = 6'b101011;
   localparam logic [NB_OP-1:0] OP_SLL  = 6'b000000;
   localparam logic [NB_OP-1:0] OP_SRL  = 6'b000010;
   localparam logic [NB_OP-1:0] OP_SRA  = 6'b000011;

   localparam int NB_FLAGS = 5;
   localparam int ZERO     = 0;
   localparam int NEG      = 1;
   localparam int CARRY    = 2;
   localparam int OVF      = 3;
   localparam int ILLEGAL  = 4;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result plus zero/negative/carry/overflow/illegal
// flags for one operand pair. Sits between the two pipeline registers.
module alu_core
   import alu_pkg::*;
#(
   parameter int NB_DATA   = 8,
   parameter int NB_OPCODE = 6,
   parameter int NB_SHAMT  = $clog2(NB_DATA)
)
(
   input  logic [NB_DATA-1:0]   i_a,
   input  logic [NB_DATA-1:0]   i_b,
   input  logic [NB_OPCODE-1:0] i_opcode,
   output logic [NB_DATA-1:0]   o_result,
   output logic [NB_FLAGS-1:0]  o_flags
);

   localparam int MSB = NB_DATA - 1;

   logic signed [NB_DATA-1:0] a_s;
   logic signed [NB_DATA-1:0] b_s;
   logic signed [NB_DATA:0]   a_ext;
   logic        [NB_SHAMT-1:0] sh;
   logic [NB_DATA:0]          sum;
   logic [NB_DATA:0]          dif;
   logic [NB_DATA:0]          sll_x;
   logic [NB_DATA:0]          srl_x;
   logic signed [NB_DATA:0]   sra_x;
   logic [NB_DATA-1:0]        res;
   logic                      cry;
   logic                      ovf;
   logic                      ill;

   assign a_s   = i_a;
   assign b_s   = i_b;
   assign sh    = i_b[NB_SHAMT-1:0];
   assign sum   = {1'b0, i_a} + {1'b0, i_b};
   assign dif   = {1'b0, i_a} - {1'b0, i_b};
   // One guard bit on each shift catches the last bit shifted out.
   assign sll_x = {1'b0, i_a} << sh;
   assign srl_x = {i_a, 1'b0} >> sh;
   assign a_ext = {i_a, 1'b0};
   assign sra_x = a_ext >>> sh;

   always_comb begin
      res = '0;
      cry = 1'b0;
      ovf = 1'b0;
      ill = 1'b0;
      case (i_opcode)
         NB_OPCODE'(OP_ADD): begin
            res = sum[NB_DATA-1:0];
            cry = sum[NB_DATA];
            ovf = (i_a[MSB] == i_b[MSB]) && (sum[MSB] != i_a[MSB]);
         end
         NB_OPCODE'(OP_SUB): begin
            res = dif[NB_DATA-1:0];
            cry = dif[NB_DATA];
            ovf = (i_a[MSB] != i_b[MSB]) && (dif[MSB] != i_a[MSB]);
         end
         NB_OPCODE'(OP_AND):  res = i_a & i_b;
         NB_OPCODE'(OP_OR):   res = i_a | i_b;
         NB_OPCODE'(OP_XOR):  res = i_a ^ i_b;
         NB_OPCODE'(OP_NOR):  res = ~(i_a | i_b);
         NB_OPCODE'(OP_SLT):  res = {{(NB_DATA-1){1'b0}}, (a_s < b_s)};
         NB_OPCODE'(OP_SLTU): res = {{(NB_DATA-1){1'b0}}, (i_a < i_b)};
         NB_OPCODE'(OP_SLL): begin
            res = sll_x[NB_DATA-1:0];
            cry = sll_x[NB_DATA];
         end
         NB_OPCODE'(OP_SRL): begin
            res = srl_x[NB_DATA:1];
            cry = srl_x[0];
         end
         NB_OPCODE'(OP_SRA): begin
            res = sra_x[NB_DATA:1];
            cry = sra_x[0];
         end
         default: ill = 1'b1;
      endcase
   end

   assign o_result        = res;
   assign o_flags[ZERO]    = ~ill & (res == '0);
   assign o_flags[NEG]     = ~ill & res[MSB];
   assign o_flags[CARRY]   = cry;
   assign o_flags[OVF]     = ovf;
   assign o_flags[ILLEGAL] = ill;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready wrapper around alu_core: operand register, then
// result/flag register. Full throughput, lossless backpressure.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int NB_DATA   = 8,
   parameter int NB_OPCODE = 6,
   parameter int NB_SHAMT  = $clog2(NB_DATA)
)
(
   input  logic                 i_clock,
   input  logic                 i_reset_n,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [NB_DATA-1:0]   i_first_operator,
   input  logic [NB_DATA-1:0]   i_second_operator,
   input  logic [NB_OPCODE-1:0] i_opcode,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [NB_DATA-1:0]   o_result,
   output logic                 o_zero,
   output logic                 o_negative,
   output logic                 o_carry,
   output logic                 o_overflow,
   output logic                 o_illegal
);

   logic                 vld_p1;
   logic                 vld_p2;
   logic                 s1_en;
   logic                 s2_en;
   logic [NB_DATA-1:0]   a_p1;
   logic [NB_DATA-1:0]   b_p1;
   logic [NB_OPCODE-1:0] op_p1;
   logic [NB_DATA-1:0]   res_c;
   logic [NB_FLAGS-1:0]  flg_c;
   logic [NB_DATA-1:0]   res_p2;
   logic [NB_FLAGS-1:0]  flg_p2;
   logic [NB_FLAGS-1:0]  flg_out;

   assign s2_en   = ~vld_p2 | i_ready;
   assign s1_en   = ~vld_p1 | s2_en;
   assign o_ready = s1_en;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else begin
         if (s1_en) vld_p1 <= i_valid;
         if (s2_en) vld_p2 <= vld_p1;
      end
   end

   // ---- stage 1: operand capture ----
   always_ff @(posedge i_clock) begin
      if (i_valid & s1_en) begin
         a_p1  <= i_first_operator;
         b_p1  <= i_second_operator;
         op_p1 <= i_opcode;
      end
   end

   alu_core #(
      .NB_DATA   (NB_DATA),
      .NB_OPCODE (NB_OPCODE),
      .NB_SHAMT  (NB_SHAMT)
   ) u_core (
      .i_a      (a_p1),
      .i_b      (b_p1),
      .i_opcode (op_p1),
      .o_result (res_c),
      .o_flags  (flg_c)
   );

   // ---- stage 2: result and flag register ----
   always_ff @(posedge i_clock) begin
      if (s2_en & vld_p1) begin
         res_p2 <= res_c;
         flg_p2 <= flg_c;
      end
   end

   // Data registers carry no reset; masking by the stage valid keeps the
   // outputs at zero whenever nothing (or nothing since reset) is held.
   assign o_valid    = vld_p2;
   assign o_result   = vld_p2 ? res_p2 : '0;
   assign flg_out    = vld_p2 ? flg_p2 : '0;
   assign o_zero     = flg_out[ZERO];
   assign o_negative = flg_out[NEG];
   assign o_carry    = flg_out[CARRY];
   assign o_overflow = flg_out[OVF];
   assign o_illegal  = flg_out[ILLEGAL];

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vector table, hand-written
// latency/backpressure/reset sequences, and randomized traffic vs a model.
module tb_alu_pipe;

   localparam logic [5:0] OPC_ADD  = 6'b100000;
   localparam logic [5:0] OPC_SUB  = 6'b100010;
   localparam logic [5:0] OPC_AND  = 6'b100100;
   localparam logic [5:0] OPC_OR   = 6'b100101;
   localparam logic [5:0] OPC_XOR  = 6'b100110;
   localparam logic [5:0] OPC_NOR  = 6'b100111;
   localparam logic [5:0] OPC_SLT  = 6'b101010;
   localparam logic [5:0] OPC_SLTU = 6'b101011;
   localparam logic [5:0] OPC_SLL  = 6'b000000;
   localparam logic [5:0] OPC_SRL  = 6'b000010;
   localparam logic [5:0] OPC_SRA  = 6'b000011;

   logic       clk;
   logic       rst_n;
   logic       i_valid;
   logic       o_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic [5:0] op;
   logic       o_valid;
   logic       i_ready;
   logic [7:0] o_result;
   logic       o_zero;
   logic       o_negative;
   logic       o_carry;
   logic       o_overflow;
   logic       o_illegal;
   logic [12:0] dut_out;

   alu_pipe #(.NB_DATA(8), .NB_OPCODE(6)) dut (
      .i_clock           (clk),
      .i_reset_n         (rst_n),
      .i_valid           (i_valid),
      .o_ready           (o_ready),
      .i_first_operator  (a),
      .i_second_operator (b),
      .i_opcode          (op),
      .o_valid           (o_valid),
      .i_ready           (i_ready),
      .o_result          (o_result),
      .o_zero            (o_zero),
      .o_negative        (o_negative),
      .o_carry           (o_carry),
      .o_overflow        (o_overflow),
      .o_illegal         (o_illegal)
   );

   // {result, illegal, overflow, carry, negative, zero}
   assign dut_out = {o_result, o_illegal, o_overflow, o_carry, o_negative, o_zero};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic [4:0] flg;
   } vec_t;

   typedef struct {
      logic [12:0] exp;
      int          tag;
   } sb_t;

   vec_t tbl [15];
   sb_t  sbq [$];
   int   n_checks = 0;
   int   n_errors = 0;
   logic acc;
   logic xfer;
   logic held;
   logic [12:0] held_out;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference model from the operation definitions, using integer arithmetic.
   function automatic logic [12:0] model(input logic [5:0] o, input logic [7:0] x, input logic [7:0] y);
      int ua = x;
      int ub = y;
      int sa = $signed(x);
      int sb = $signed(y);
      int sh = y % 8;
      int r  = 0;
      int s;
      bit c = 0, v = 0, ill = 0;
      logic [7:0] r8;
      case (o)
         OPC_ADD:  begin r = ua + ub; c = (r > 255); s = sa + sb; v = (s > 127) || (s < -128); end
         OPC_SUB:  begin r = ua - ub; c = (ua < ub); s = sa - sb; v = (s > 127) || (s < -128); end
         OPC_AND:  r = ua & ub;
         OPC_OR:   r = ua | ub;
         OPC_XOR:  r = ua ^ ub;
         OPC_NOR:  r = ~(ua | ub);
         OPC_SLT:  r = (sa < sb) ? 1 : 0;
         OPC_SLTU: r = (ua < ub) ? 1 : 0;
         OPC_SLL:  begin r = ua * (1 << sh); c = (sh > 0) && (((ua >> (8 - sh)) & 1) == 1); end
         OPC_SRL:  begin r = ua / (1 << sh); c = (sh > 0) && (((ua >> (sh - 1)) & 1) == 1); end
         OPC_SRA:  begin r = sa >>> sh;      c = (sh > 0) && (((ua >> (sh - 1)) & 1) == 1); end
         default:  ill = 1;
      endcase
      r8 = r[7:0];
      return {r8, ill, v, c, (!ill && r8[7]), (!ill && r8 == 8'h00)};
   endfunction

   // One clock cycle: drive after the falling edge, settle, then score the
   // transfers that the next rising edge will perform.
   task automatic cyc(input logic v, input logic [5:0] o, input logic [7:0] x, input logic [7:0] y,
                      input logic rdy, input logic [12:0] exp, input int tag);
      sb_t e;
      @(negedge clk);
      i_valid = v; op = o; a = x; b = y; i_ready = rdy;
      #1;
      if (held) check("hold while stalled", {19'b0, o_valid, dut_out}, {19'b0, 1'b1, held_out});
      xfer = o_valid & i_ready;
      acc  = i_valid & o_ready;
      if (xfer) begin
         if (sbq.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected output: got %h expected none", dut_out);
         end else begin
            e = sbq.pop_front();
            check($sformatf("output tag%0d", e.tag), {19'b0, dut_out}, {19'b0, e.exp});
         end
      end
      if (acc) sbq.push_back('{exp, tag});
      held     = o_valid & ~i_ready;
      held_out = dut_out;
   endtask

   int k;
   int nx;
   logic [7:0] vv;
   logic [5:0] ops [12];
   logic [5:0] ro;
   logic [7:0] ra;
   logic [7:0] rb;

   initial begin
      tbl[0]  = '{OPC_ADD,  8'h7F, 8'h01, 8'h80, 5'b01010};
      tbl[1]  = '{OPC_SUB,  8'h00, 8'h01, 8'hFF, 5'b00110};
      tbl[2]  = '{OPC_SRA,  8'h80, 8'h0B, 8'hF0, 5'b00010};
      tbl[3]  = '{OPC_SRL,  8'h80, 8'h0B, 8'h10, 5'b00000};
      tbl[4]  = '{OPC_SLL,  8'h81, 8'h01, 8'h02, 5'b00100};
      tbl[5]  = '{OPC_SLT,  8'hFF, 8'h01, 8'h01, 5'b00000};
      tbl[6]  = '{OPC_SLTU, 8'hFF, 8'h01, 8'h00, 5'b00001};
      tbl[7]  = '{6'b111111, 8'h05, 8'h03, 8'h00, 5'b10000};
      tbl[8]  = '{OPC_AND,  8'hF0, 8'h3C, 8'h30, 5'b00000};
      tbl[9]  = '{OPC_OR,   8'h0F, 8'hF0, 8'hFF, 5'b00010};
      tbl[10] = '{OPC_XOR,  8'hAA, 8'hAA, 8'h00, 5'b00001};
      tbl[11] = '{OPC_NOR,  8'h00, 8'h00, 8'hFF, 5'b00010};
      tbl[12] = '{OPC_ADD,  8'hFF, 8'h01, 8'h00, 5'b00101};
      tbl[13] = '{OPC_SUB,  8'h80, 8'h01, 8'h7F, 5'b01000};
      tbl[14] = '{OPC_SLL,  8'h81, 8'h08, 8'h81, 5'b00010};
      ops = '{OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR, OPC_NOR,
              OPC_SLT, OPC_SLTU, OPC_SLL, OPC_SRL, OPC_SRA, 6'b111111};

      held = 1'b0; held_out = '0;
      rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0; a = '0; b = '0; op = '0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("reset o_valid", {31'b0, o_valid}, 0);
      check("reset outputs", {19'b0, dut_out}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("o_ready after reset", {31'b0, o_ready}, 1);

      // latency: accept, then o_valid exactly two edges later
      cyc(1'b1, OPC_ADD, 8'h7F, 8'h01, 1'b1, {8'h80, 5'b01010}, 1);
      cyc(1'b0, 6'h0, 8'h0, 8'h0, 1'b1, '0, 0);
      check("latency edge1 o_valid", {31'b0, o_valid}, 0);
      cyc(1'b0, 6'h0, 8'h0, 8'h0, 1'b1, '0, 0);
      check("latency edge2 o_valid", {31'b0, o_valid}, 1);

      // directed vector table, back to back
      for (int i = 0; i < 15; i++)
         cyc(1'b1, tbl[i].op, tbl[i].a, tbl[i].b, 1'b1, {tbl[i].res, tbl[i].flg}, 10 + i);
      for (int i = 0; i < 10 && sbq.size() > 0; i++)
         cyc(1'b0, 6'h0, 8'h0, 8'h0, 1'b1, '0, 0);
      check("table drained", sbq.size(), 0);

      // backpressure: four ADDs offered while downstream stalls five cycles
      k = 0;
      for (int c = 0; c < 5; c++) begin
         vv = 8'(k + 1);
         cyc(1'b1, OPC_ADD, vv, vv, 1'b0, {8'(vv + vv), 5'b00000}, 200 + k);
         if (acc) k++;
         if (c >= 2) begin
            check("bp result held", {24'b0, o_result}, 32'h02);
            check("bp o_ready low", {31'b0, o_ready}, 0);
         end
      end
      check("bp accepted count", k, 2);
      nx = 0;
      for (int c = 0; c < 4; c++) begin
         vv = 8'(k + 1);
         cyc(k < 4, OPC_ADD, vv, vv, 1'b1, {8'(vv + vv), 5'b00000}, 200 + k);
         if (acc) k++;
         if (xfer) nx++;
      end
      check("bp one per cycle", nx, 4);
      check("bp all accepted", k, 4);
      check("bp drained", sbq.size(), 0);

      // reset with both stages full
      cyc(1'b1, OPC_ADD, 8'h10, 8'h10, 1'b0, {8'h20, 5'b00000}, 300);
      cyc(1'b1, OPC_ADD, 8'h11, 8'h11, 1'b0, {8'h22, 5'b00000}, 301);
      cyc(1'b0, 6'h0, 8'h0, 8'h0, 1'b0, '0, 0);
      check("pre-reset o_valid", {31'b0, o_valid}, 1);
      check("pre-reset o_ready", {31'b0, o_ready}, 0);
      rst_n = 1'b0;
      #1;
      check("async reset o_valid", {31'b0, o_valid}, 0);
      check("async reset outputs", {19'b0, dut_out}, 0);
      sbq.delete();
      held = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("o_ready after mid reset", {31'b0, o_ready}, 1);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 6'h0, 8'h0, 8'h0, 1'b1, '0, 0);
         check("no stale output", {31'b0, o_valid}, 0);
      end

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         ro = ops[$urandom_range(0, 11)];
         if ($urandom_range(0, 15) == 0) ro = 6'($urandom);
         ra = 8'($urandom);
         rb = 8'($urandom);
         cyc($urandom_range(0, 9) < 7, ro, ra, rb, $urandom_range(0, 9) < 6,
             model(ro, ra, rb), 1000 + i);
      end
      for (int i = 0; i < 30 && sbq.size() > 0; i++)
         cyc(1'b0, 6'h0, 8'h0, 8'h0, 1'b1, '0, 0);
      check("random drained", sbq.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
